// File: rtl/draw_scheduler.sv
// Frame scheduler for the Pong display: walks the scan position, streams pixels to the
// LCD writer over valid/ready, and pulses the object-update tick between frames.
module draw_scheduler #(
  parameter int unsigned WIDTH         = 240,
  parameter int unsigned HEIGHT        = 320,
  parameter int unsigned BLANK_CYCLES  = 4,
  parameter int unsigned UPDATE_FRAMES = 1,
  parameter logic [15:0] BALL_COLOUR   = 16'hFFFF,
  parameter logic [15:0] PADDLE_COLOUR = 16'h07E0,
  parameter logic [15:0] SCORE_COLOUR  = 16'hF800,
  parameter logic [15:0] BG_COLOUR     = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        drawBall,
  input  logic        drawPaddle,
  input  logic        drawScore,
  input  logic        pixelReady,
  output logic [7:0]  xCount,
  output logic [8:0]  yCount,
  output logic        pixelWrite,
  output logic [15:0] pixelColour,
  output logic        updateTick,
  output logic        frameDone
);

  localparam int unsigned BW = $clog2(BLANK_CYCLES);
  localparam int unsigned FW = (UPDATE_FRAMES > 1) ? $clog2(UPDATE_FRAMES) : 1;

  localparam logic [7:0]    X_LAST = 8'(WIDTH - 1);
  localparam logic [8:0]    Y_LAST = 9'(HEIGHT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [FW-1:0] F_LAST = FW'(UPDATE_FRAMES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAW  = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;
  localparam logic [1:0] S_PAUSE = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [7:0]    r_x;
  logic [8:0]    r_y;
  logic [BW-1:0] r_blank_cnt;
  logic [FW-1:0] r_frame_cnt;
  logic          r_pixel_write;
  logic          r_update_tick;
  logic          r_frame_done;

  logic w_accept;
  logic w_x_last;
  logic w_y_last;
  logic w_frame_end;
  logic w_blank_last;

  assign w_accept     = (r_state == S_DRAW) && r_pixel_write && pixelReady;
  assign w_x_last     = (r_x == X_LAST);
  assign w_y_last     = (r_y == Y_LAST);
  assign w_frame_end  = w_accept && w_x_last && w_y_last;
  assign w_blank_last = (r_state == S_BLANK) && (r_blank_cnt == B_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_DRAW;
      S_DRAW:  if (w_frame_end) w_next = S_BLANK;
      S_BLANK: if (w_blank_last) w_next = pause ? S_PAUSE : S_DRAW;
      S_PAUSE: if (!pause) w_next = S_DRAW;
      default: w_next = S_IDLE;
    endcase
  end

  // Scan position, blank/frame counters and registered handshake/pulse outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_x           <= '0;
      r_y           <= '0;
      r_blank_cnt   <= '0;
      r_frame_cnt   <= '0;
      r_pixel_write <= 1'b0;
      r_update_tick <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_x_last) begin
          r_x <= '0;
          r_y <= w_y_last ? 9'd0 : r_y + 9'd1;
        end else begin
          r_x <= r_x + 8'd1;
        end
      end
      if ((r_state == S_BLANK) && !w_blank_last) r_blank_cnt <= r_blank_cnt + BW'(1);
      else                                       r_blank_cnt <= '0;
      if (w_frame_end) begin
        if (r_frame_cnt == F_LAST) r_frame_cnt <= '0;
        else                       r_frame_cnt <= r_frame_cnt + FW'(1);
      end
      r_update_tick <= w_frame_end && (r_frame_cnt == F_LAST);
      r_frame_done  <= w_frame_end;
      r_pixel_write <= (w_next == S_DRAW);
    end
  end

  // Fixed-priority colour select; ball over paddle over score over background
  always_comb begin
    pixelColour = BG_COLOUR;
    if (drawBall)        pixelColour = BALL_COLOUR;
    else if (drawPaddle) pixelColour = PADDLE_COLOUR;
    else if (drawScore)  pixelColour = SCORE_COLOUR;
  end

  assign xCount     = r_x;
  assign yCount     = r_y;
  assign pixelWrite = r_pixel_write;
  assign updateTick = r_update_tick;
  assign frameDone  = r_frame_done;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: colour table, scan order, backpressure, update rate,
// pause at frame boundary, and asynchronous reset mid-frame on a full-size instance.
module tb_draw_scheduler;

  logic        clock = 1'b0;
  logic        reset, start, pause;
  logic        drawBall, drawPaddle, drawScore, pixelReady;
  logic [7:0]  xCount;
  logic [8:0]  yCount;
  logic        pixelWrite, updateTick, frameDone;
  logic [15:0] pixelColour;

  logic        b_reset, b_start;
  logic [7:0]  b_x;
  logic [8:0]  b_y;
  logic        b_pw, b_ut, b_fd;
  logic [15:0] b_col;

  int checks = 0;
  int errors = 0;
  int n_tick = 0;
  int n_fd   = 0;
  int n_bad  = 0;

  always #5 clock = ~clock;

  draw_scheduler #(
    .WIDTH(4), .HEIGHT(3), .BLANK_CYCLES(4), .UPDATE_FRAMES(3)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .pause(pause),
    .drawBall(drawBall), .drawPaddle(drawPaddle), .drawScore(drawScore),
    .pixelReady(pixelReady), .xCount(xCount), .yCount(yCount),
    .pixelWrite(pixelWrite), .pixelColour(pixelColour),
    .updateTick(updateTick), .frameDone(frameDone)
  );

  draw_scheduler dut_big (
    .clock(clock), .reset(b_reset), .start(b_start), .pause(1'b0),
    .drawBall(drawBall), .drawPaddle(drawPaddle), .drawScore(drawScore),
    .pixelReady(pixelReady), .xCount(b_x), .yCount(b_y),
    .pixelWrite(b_pw), .pixelColour(b_col),
    .updateTick(b_ut), .frameDone(b_fd)
  );

  // Pulse bookkeeping for the small instance
  always @(negedge clock) begin
    if (reset) begin
      if (updateTick) n_tick++;
      if (frameDone) n_fd++;
      if (updateTick && (pixelWrite || !frameDone)) n_bad++;
    end
  end

  typedef struct {
    logic        ball;
    logic        paddle;
    logic        score;
    logic [15:0] exp;
  } col_vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One 4x3 frame from its first DRAW cycle through BLANK (and PAUSE when requested)
  task automatic run_frame(input int pause_at, input bit bp, input int exp_tick);
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    int p   = 0;
    int cyc = 0;
    logic rdy;
    while (p < 12 && cyc < 200) begin
      chk("scan_x", 32'(xCount), p % 4);
      chk("scan_y", 32'(yCount), p / 4);
      chk("draw_write", 32'(pixelWrite), 1);
      chk("draw_colour", 32'(pixelColour), 32'h07E0);
      rdy = bp ? pat[cyc % 6][0] : 1'b1;
      pixelReady = rdy;
      if (p == pause_at) pause = 1'b1;
      tick();
      if (rdy) p++;
      cyc++;
      if (p < 12) begin
        chk("done_mid_frame", 32'(frameDone), 0);
        chk("tick_mid_frame", 32'(updateTick), 0);
      end
    end
    if (p != 12) chk("frame_timeout", p, 12);
    pixelReady = 1'b1;
    for (int b = 0; b < 4; b++) begin
      chk("blank_write", 32'(pixelWrite), 0);
      chk("blank_done", 32'(frameDone), (b == 0) ? 1 : 0);
      chk("blank_tick", 32'(updateTick), (b == 0) ? exp_tick : 0);
      tick();
    end
    if (pause_at >= 0) begin
      for (int k = 0; k < 5; k++) begin
        chk("pause_write", 32'(pixelWrite), 0);
        chk("pause_tick", 32'(updateTick), 0);
        tick();
      end
      pause = 1'b0;
      tick();
    end
    chk("next_frame_write", 32'(pixelWrite), 1);
    chk("next_frame_x", 32'(xCount), 0);
    chk("next_frame_y", 32'(yCount), 0);
  endtask

  initial begin
    col_vec_t cv[8];
    cv[0] = '{1'b1, 1'b1, 1'b1, 16'hFFFF};
    cv[1] = '{1'b0, 1'b1, 1'b1, 16'h07E0};
    cv[2] = '{1'b0, 1'b0, 1'b1, 16'hF800};
    cv[3] = '{1'b0, 1'b0, 1'b0, 16'h0000};
    cv[4] = '{1'b1, 1'b0, 1'b0, 16'hFFFF};
    cv[5] = '{1'b0, 1'b1, 1'b0, 16'h07E0};
    cv[6] = '{1'b1, 1'b0, 1'b1, 16'hFFFF};
    cv[7] = '{1'b1, 1'b1, 1'b0, 16'hFFFF};

    reset = 1'b0; b_reset = 1'b0;
    start = 1'b0; b_start = 1'b0; pause = 1'b0;
    drawBall = 1'b0; drawPaddle = 1'b0; drawScore = 1'b0;
    pixelReady = 1'b1;

    #3;
    chk("rst_x", 32'(xCount), 0);
    chk("rst_y", 32'(yCount), 0);
    chk("rst_write", 32'(pixelWrite), 0);
    chk("rst_tick", 32'(updateTick), 0);
    chk("rst_done", 32'(frameDone), 0);
    tick();
    reset = 1'b1; b_reset = 1'b1;

    // Pause is ignored in IDLE
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_write", 32'(pixelWrite), 0);
    end
    pause = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drawBall = cv[i].ball; drawPaddle = cv[i].paddle; drawScore = cv[i].score;
      #1;
      chk("colour_prio", 32'(pixelColour), 32'(cv[i].exp));
      tick();
    end

    // Full-size instance: reset mid-frame at (37,5)
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("big_first_write", 32'(b_pw), 1);
    for (int i = 0; i < 5 * 240 + 37; i++) tick();
    chk("big_pre_x", 32'(b_x), 37);
    chk("big_pre_y", 32'(b_y), 5);
    b_reset = 1'b0;
    #1;
    chk("big_rst_x", 32'(b_x), 0);
    chk("big_rst_y", 32'(b_y), 0);
    chk("big_rst_write", 32'(b_pw), 0);
    #1;
    b_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("big_idle_write", 32'(b_pw), 0);
      chk("big_idle_x", 32'(b_x), 0);
    end

    // Start beats pause in IDLE; objects held as paddle pixels for the whole run
    drawBall = 1'b0; drawPaddle = 1'b1; drawScore = 1'b0;
    start = 1'b1; pause = 1'b1;
    tick();
    start = 1'b0; pause = 1'b0;
    chk("start_write", 32'(pixelWrite), 1);
    chk("start_x", 32'(xCount), 0);
    chk("start_y", 32'(yCount), 0);

    run_frame(-1, 1'b0, 0);
    run_frame(-1, 1'b1, 0);
    run_frame(5, 1'b0, 1);
    run_frame(-1, 1'b1, 0);
    run_frame(-1, 1'b0, 0);
    run_frame(-1, 1'b0, 1);

    chk("tick_count", n_tick, 2);
    chk("done_count", n_fd, 6);
    chk("tick_overlap", n_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
